// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: merges stall requests into a freeze mask,
// stretches flushes, holds the redirect PC and watches for stuck stalls.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES  = 6,
   parameter int FLUSH_HOLD  = 1,
   parameter int ADDR_W      = 32,
   parameter int WDOG_W      = 8,
   parameter int STALL_LIMIT = 200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_STAGES-1:0] stall_req_i,
   input  logic                  flush_req_i,
   input  logic [ADDR_W-1:0]     flush_pc_i,
   input  logic                  wdog_clr_i,
   output logic [NUM_STAGES-1:0] stall_o,
   output logic                  flush_o,
   output logic [ADDR_W-1:0]     new_pc_o,
   output logic                  new_pc_valid_o,
   output logic [WDOG_W-1:0]     stall_cnt_o,
   output logic                  wdog_trip_o
);

   localparam int HOLD_W = 4;

   logic [HOLD_W-1:0]     hold_cnt;
   logic [ADDR_W-1:0]     pc_q;
   logic [WDOG_W-1:0]     stall_cnt;
   logic                  wdog_trip;

   logic [NUM_STAGES-1:0] stall_mask;
   logic [NUM_STAGES-1:0] stall_int;
   logic                  flush_int;
   logic [WDOG_W-1:0]     stall_cnt_nxt;

   function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
      if (v == {WDOG_W{1'b1}})
         return v;
      else
         return v + 1'b1;
   endfunction

   // A stage freezes whenever it or any later stage is stalled.
   always_comb begin
      stall_mask = '0;
      for (int j = 0; j < NUM_STAGES; j++)
         stall_mask[j] = |(stall_req_i >> j);
   end

   assign flush_int     = flush_req_i | (hold_cnt != '0);
   assign stall_int     = flush_int ? '0 : stall_mask;
   assign stall_cnt_nxt = (stall_int == '0) ? '0 : sat_inc(stall_cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt  <= '0;
         pc_q      <= '0;
         stall_cnt <= '0;
         wdog_trip <= 1'b0;
      end else begin
         if (flush_req_i)
            hold_cnt <= HOLD_W'(FLUSH_HOLD);
         else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;

         if (flush_req_i)
            pc_q <= flush_pc_i;

         stall_cnt <= stall_cnt_nxt;

         // Trip only on the arrival at the limit so a saturated count cannot re-fire.
         if (stall_cnt_nxt == WDOG_W'(STALL_LIMIT) && stall_cnt != WDOG_W'(STALL_LIMIT))
            wdog_trip <= 1'b1;
         else if (wdog_clr_i)
            wdog_trip <= 1'b0;
      end
   end

   assign stall_o        = rst ? stall_int : '0;
   assign flush_o        = rst & flush_int;
   assign new_pc_o       = rst ? (flush_req_i ? flush_pc_i : pc_q) : '0;
   assign new_pc_valid_o = rst & flush_req_i;
   assign stall_cnt_o    = rst ? stall_cnt : '0;
   assign wdog_trip_o    = rst & wdog_trip;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle vector table on one instance
// (hold 1, limit 4) plus hand sequences on a second (hold 3, 3-bit counter).
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall_req;
   logic        flush_req;
   logic [31:0] flush_pc;
   logic        wdog_clr;

   logic [5:0]  stall_a, stall_b;
   logic        flush_a, flush_b;
   logic [31:0] pc_a, pc_b;
   logic        pcv_a, pcv_b;
   logic [7:0]  cnt_a;
   logic [2:0]  cnt_b;
   logic        trip_a, trip_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.NUM_STAGES(6), .FLUSH_HOLD(1), .ADDR_W(32), .WDOG_W(8), .STALL_LIMIT(4)) dut_a (
      .clk(clk), .rst(rst), .stall_req_i(stall_req), .flush_req_i(flush_req),
      .flush_pc_i(flush_pc), .wdog_clr_i(wdog_clr), .stall_o(stall_a), .flush_o(flush_a),
      .new_pc_o(pc_a), .new_pc_valid_o(pcv_a), .stall_cnt_o(cnt_a), .wdog_trip_o(trip_a));

   pipe_hazard_ctrl #(.NUM_STAGES(6), .FLUSH_HOLD(3), .ADDR_W(32), .WDOG_W(3), .STALL_LIMIT(4)) dut_b (
      .clk(clk), .rst(rst), .stall_req_i(stall_req), .flush_req_i(flush_req),
      .flush_pc_i(flush_pc), .wdog_clr_i(wdog_clr), .stall_o(stall_b), .flush_o(flush_b),
      .new_pc_o(pc_b), .new_pc_valid_o(pcv_b), .stall_cnt_o(cnt_b), .wdog_trip_o(trip_b));

   typedef struct {
      logic [5:0]  req;
      logic        fl;
      logic [31:0] pc;
      logic        clr;
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
      logic        e_pcv;
      logic [7:0]  e_cnt;
      logic        e_trip;
   } vec_t;

   vec_t tbl[24];

   function automatic vec_t mk(logic [5:0] req, logic fl, logic [31:0] pc, logic clr,
                               logic [5:0] es, logic ef, logic [31:0] ep, logic epv,
                               logic [7:0] ec, logic et);
      vec_t v;
      v.req = req; v.fl = fl; v.pc = pc; v.clr = clr;
      v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_pcv = epv; v.e_cnt = ec; v.e_trip = et;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Stall mask, single flush, flush-over-stall, watchdog, clear and set-vs-clear
      tbl[0]  = mk(6'b000100, 0, 32'h99,  0, 6'b000111, 0, 32'h0,   0, 0, 0);
      tbl[1]  = mk(6'b010100, 0, 32'h99,  0, 6'b011111, 0, 32'h0,   0, 1, 0);
      tbl[2]  = mk(6'b100000, 0, 32'h99,  0, 6'b111111, 0, 32'h0,   0, 2, 0);
      tbl[3]  = mk(6'b000000, 0, 32'h99,  0, 6'b000000, 0, 32'h0,   0, 3, 0);
      tbl[4]  = mk(6'b000000, 0, 32'h99,  0, 6'b000000, 0, 32'h0,   0, 0, 0);
      tbl[5]  = mk(6'b000000, 1, 32'h40,  0, 6'b000000, 1, 32'h40,  1, 0, 0);
      tbl[6]  = mk(6'b000000, 0, 32'h99,  0, 6'b000000, 1, 32'h40,  0, 0, 0);
      tbl[7]  = mk(6'b000000, 0, 32'h99,  0, 6'b000000, 0, 32'h40,  0, 0, 0);
      tbl[8]  = mk(6'b001000, 1, 32'h100, 0, 6'b000000, 1, 32'h100, 1, 0, 0);
      tbl[9]  = mk(6'b001000, 0, 32'h99,  0, 6'b000000, 1, 32'h100, 0, 0, 0);
      tbl[10] = mk(6'b001000, 0, 32'h99,  0, 6'b001111, 0, 32'h100, 0, 0, 0);
      tbl[11] = mk(6'b001000, 0, 32'h99,  0, 6'b001111, 0, 32'h100, 0, 1, 0);
      tbl[12] = mk(6'b001000, 0, 32'h99,  0, 6'b001111, 0, 32'h100, 0, 2, 0);
      tbl[13] = mk(6'b001000, 0, 32'h99,  0, 6'b001111, 0, 32'h100, 0, 3, 0);
      tbl[14] = mk(6'b000001, 0, 32'h99,  0, 6'b000001, 0, 32'h100, 0, 4, 1);
      tbl[15] = mk(6'b000000, 0, 32'h99,  0, 6'b000000, 0, 32'h100, 0, 5, 1);
      tbl[16] = mk(6'b000000, 0, 32'h99,  1, 6'b000000, 0, 32'h100, 0, 0, 1);
      tbl[17] = mk(6'b100000, 0, 32'h99,  1, 6'b111111, 0, 32'h100, 0, 0, 0);
      tbl[18] = mk(6'b100000, 0, 32'h99,  0, 6'b111111, 0, 32'h100, 0, 1, 0);
      tbl[19] = mk(6'b100000, 0, 32'h99,  0, 6'b111111, 0, 32'h100, 0, 2, 0);
      tbl[20] = mk(6'b100000, 0, 32'h99,  1, 6'b111111, 0, 32'h100, 0, 3, 0);
      tbl[21] = mk(6'b000000, 0, 32'h99,  0, 6'b000000, 0, 32'h100, 0, 4, 1);
      tbl[22] = mk(6'b000000, 0, 32'h99,  1, 6'b000000, 0, 32'h100, 0, 0, 1);
      tbl[23] = mk(6'b000000, 0, 32'h99,  0, 6'b000000, 0, 32'h100, 0, 0, 0);

      // Outputs forced low while in reset, even with active requests
      rst = 1'b0; stall_req = 6'b100000; flush_req = 1'b1; flush_pc = 32'h55; wdog_clr = 1'b0;
      #2;
      chk("rst stall", 64'(stall_a), 64'h0);
      chk("rst flush", 64'(flush_a), 64'h0);
      chk("rst pcv",   64'(pcv_a),   64'h0);
      chk("rst newpc", 64'(pc_a),    64'h0);
      step();
      stall_req = '0; flush_req = 1'b0; flush_pc = '0;
      rst = 1'b1;
      step();

      for (int i = 0; i < 24; i++) begin
         stall_req = tbl[i].req; flush_req = tbl[i].fl; flush_pc = tbl[i].pc; wdog_clr = tbl[i].clr;
         #2;
         chk($sformatf("row%0d stall", i), 64'(stall_a), 64'(tbl[i].e_stall));
         chk($sformatf("row%0d flush", i), 64'(flush_a), 64'(tbl[i].e_flush));
         chk($sformatf("row%0d newpc", i), 64'(pc_a),    64'(tbl[i].e_pc));
         chk($sformatf("row%0d pcv", i),   64'(pcv_a),   64'(tbl[i].e_pcv));
         chk($sformatf("row%0d cnt", i),   64'(cnt_a),   64'(tbl[i].e_cnt));
         chk($sformatf("row%0d trip", i),  64'(trip_a),  64'(tbl[i].e_trip));
         step();
      end

      stall_req = '0; flush_req = 1'b0; wdog_clr = 1'b0; flush_pc = 32'h5;
      rst = 1'b0; #1; rst = 1'b1;

      // Two-cycle flush with hold 3: five flush cycles, last PC retained
      for (int c = 0; c < 6; c++) begin
         flush_req = (c < 2);
         flush_pc  = (c == 0) ? 32'h20 : (c == 1) ? 32'h80 : 32'h5;
         #2;
         chk($sformatf("t5 c%0d flush", c), 64'(flush_b), 64'(c < 5));
         chk($sformatf("t5 c%0d pcv", c),   64'(pcv_b),   64'(c < 2));
         chk($sformatf("t5 c%0d newpc", c), 64'(pc_b),    (c == 0) ? 64'h20 : 64'h80);
         step();
      end

      // Stall counter saturates at 7 on the 3-bit instance, trip sticky
      flush_req = 1'b0; stall_req = 6'b000010;
      for (int i = 0; i < 10; i++) begin
         #2;
         chk($sformatf("sat i%0d cnt", i),   64'(cnt_b),   64'((i > 7) ? 7 : i));
         chk($sformatf("sat i%0d trip", i),  64'(trip_b),  64'(i >= 4));
         chk($sformatf("sat i%0d stall", i), 64'(stall_b), 64'h3);
         step();
      end

      // Reset asserted mid-flush with hold_cnt at 2
      flush_req = 1'b1; flush_pc = 32'h300;
      #2;
      chk("t6 flush0", 64'(flush_b), 64'h1);
      chk("t6 stall0", 64'(stall_b), 64'h0);
      step();
      flush_req = 1'b0;
      #2;
      chk("t6 flush1", 64'(flush_b), 64'h1);
      chk("t6 cnt1",   64'(cnt_b),   64'h0);
      step();
      #2;
      chk("t6 flush2", 64'(flush_b), 64'h1);
      chk("t6 trip2",  64'(trip_b),  64'h1);
      #1 rst = 1'b0;
      #1;
      chk("t6 async flush", 64'(flush_b), 64'h0);
      chk("t6 async stall", 64'(stall_b), 64'h0);
      chk("t6 async trip",  64'(trip_b),  64'h0);
      chk("t6 async newpc", 64'(pc_b),    64'h0);
      stall_req = '0;
      #1 rst = 1'b1;
      #1;
      chk("t6 rel flush", 64'(flush_b), 64'h0);
      chk("t6 rel cnt",   64'(cnt_b),   64'h0);
      chk("t6 rel trip",  64'(trip_b),  64'h0);
      chk("t6 rel newpc", 64'(pc_b),    64'h0);
      step();
      #2;
      chk("t6 post flush", 64'(flush_b), 64'h0);
      chk("t6 post cnt",   64'(cnt_b),   64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
